// File: rtl/svm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | svm_pkg : feature word type and saturation limits shared with hw_svm |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package svm_pkg;

  typedef logic signed [31:0] feature_t;

  localparam feature_t FEAT_MAX = 32'h7FFF_FFFF;
  localparam feature_t FEAT_MIN = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/svm_sat_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | svm_sat_round : round-half-up shift and saturate to a 32-bit feature |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module svm_sat_round
  import svm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W+18:0] p_i,
  output feature_t                y_o,
  output logic                    sat_o
);

  localparam int RW = IN_W + 20;
  localparam int EW = (RW > 33) ? RW : 33;

  logic signed [RW-1:0] w_pe;
  logic signed [RW-1:0] w_r;
  logic signed [EW-1:0] w_rx;
  logic                 w_ovf;

  assign w_pe = RW'(p_i);

  // One guard bit above the product keeps the rounding add from overflowing.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] c_HALF = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign w_r = (w_pe + c_HALF) >>> SHIFT;
    end else begin : g_pass
      assign w_r = w_pe;
    end
  endgenerate

  assign w_rx = EW'(w_r);

  // Fits in 32 bits only when every bit from 31 upward matches the sign.
  assign w_ovf = !((&w_rx[EW-1:31]) || !(|w_rx[EW-1:31]));
  assign sat_o = w_ovf;
  assign y_o   = w_ovf ? (w_rx[EW-1] ? FEAT_MIN : FEAT_MAX) : feature_t'(w_rx[31:0]);

endmodule
`default_nettype wire

// File: rtl/svm_feature_scaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | svm_feature_scaler : (x-OFFSET)*SCALE >>> SHIFT, rounded, saturated  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module svm_feature_scaler
  import svm_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OFFSET = 0,
  parameter int SCALE  = 1,
  parameter int SHIFT  = 0,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  raw,
  input  logic                    raw_valid,
  output logic                    raw_ready,
  output logic signed [31:0]      test,
  output logic                    test_valid,
  input  logic                    test_ready,
  output logic [CNT_W-1:0]        sat_count,
  output logic                    sat_flag
);

  localparam int                     PW        = IN_W + 19;
  localparam logic signed [IN_W:0]   c_OFFSET  = (IN_W + 1)'(OFFSET);
  localparam logic signed [17:0]     c_SCALE   = 18'(SCALE);
  localparam logic [CNT_W-1:0]       c_CNT_MAX = '1;

  logic                   en;
  logic                   x_vld_q, diff_vld_q, prod_vld_q, out_vld_q;
  logic signed [IN_W-1:0] x_q;
  logic signed [IN_W:0]   diff_q, diff_d;
  logic signed [PW-1:0]   prod_q, prod_d;
  feature_t               out_q, out_d;
  logic                   sat_q, sat_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // A single enable stalls the whole pipe; bubbles are not squeezed out.
  assign en        = !out_vld_q || test_ready;
  assign raw_ready = en;

  assign diff_d = (IN_W + 1)'(x_q) - c_OFFSET;
  assign prod_d = PW'(diff_q) * PW'(c_SCALE);

  svm_sat_round #(
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_sat_round (
    .p_i   (prod_q),
    .y_o   (out_d),
    .sat_o (sat_d)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (out_vld_q && test_ready && sat_q && (cnt_q != c_CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_vld_q    <= 1'b0;
      diff_vld_q <= 1'b0;
      prod_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      x_q        <= '0;
      diff_q     <= '0;
      prod_q     <= '0;
      out_q      <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (en) begin
        x_vld_q    <= raw_valid;
        diff_vld_q <= x_vld_q;
        prod_vld_q <= diff_vld_q;
        out_vld_q  <= prod_vld_q;
        // Data registers only load real samples so test keeps its last word.
        if (raw_valid)  x_q    <= raw;
        if (x_vld_q)    diff_q <= diff_d;
        if (diff_vld_q) prod_q <= prod_d;
        if (prod_vld_q) begin
          out_q <= out_d;
          sat_q <= sat_d;
        end
      end
    end
  end

  assign test       = out_q;
  assign test_valid = out_vld_q;
  assign sat_flag   = sat_q && out_vld_q;
  assign sat_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_svm_feature_scaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_svm_feature_scaler : directed self-checking bench, four configs   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_svm_feature_scaler;
  import svm_pkg::*;

  logic clk;
  logic rst;

  // A: defaults
  logic signed [15:0] a_raw;
  logic a_rv, a_rr, a_tv, a_tr, a_sf;
  logic signed [31:0] a_t;
  logic [15:0] a_cnt;
  // B: OFFSET=100 SCALE=3 SHIFT=1
  logic signed [15:0] b_raw;
  logic b_rv, b_rr, b_tv, b_tr, b_sf;
  logic signed [31:0] b_t;
  logic [15:0] b_cnt;
  // C: OFFSET=-32768 SCALE=131071 SHIFT=0 CNT_W=2
  logic signed [15:0] c_raw;
  logic c_rv, c_rr, c_tv, c_tr, c_sf;
  logic signed [31:0] c_t;
  logic [1:0] c_cnt;
  // D: OFFSET=-32768 SCALE=-131072 SHIFT=0
  logic signed [15:0] d_raw;
  logic d_rv, d_rr, d_tv, d_tr, d_sf;
  logic signed [31:0] d_t;
  logic [15:0] d_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  svm_feature_scaler u_dut_a (
    .clk(clk), .rst(rst), .raw(a_raw), .raw_valid(a_rv), .raw_ready(a_rr),
    .test(a_t), .test_valid(a_tv), .test_ready(a_tr), .sat_count(a_cnt), .sat_flag(a_sf)
  );

  svm_feature_scaler #(.OFFSET(100), .SCALE(3), .SHIFT(1)) u_dut_b (
    .clk(clk), .rst(rst), .raw(b_raw), .raw_valid(b_rv), .raw_ready(b_rr),
    .test(b_t), .test_valid(b_tv), .test_ready(b_tr), .sat_count(b_cnt), .sat_flag(b_sf)
  );

  svm_feature_scaler #(.OFFSET(-32768), .SCALE(131071), .SHIFT(0), .CNT_W(2)) u_dut_c (
    .clk(clk), .rst(rst), .raw(c_raw), .raw_valid(c_rv), .raw_ready(c_rr),
    .test(c_t), .test_valid(c_tv), .test_ready(c_tr), .sat_count(c_cnt), .sat_flag(c_sf)
  );

  svm_feature_scaler #(.OFFSET(-32768), .SCALE(-131072), .SHIFT(0)) u_dut_d (
    .clk(clk), .rst(rst), .raw(d_raw), .raw_valid(d_rv), .raw_ready(d_rr),
    .test(d_t), .test_valid(d_tv), .test_ready(d_tr), .sat_count(d_cnt), .sat_flag(d_sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++; if (a_tv !== 1'b0) begin n_fail++; $display("FAIL reset_tv: got %b expected 0", a_tv); end
    n_tests++; if (a_t !== 32'h0) begin n_fail++; $display("FAIL reset_test: got %h expected 00000000", a_t); end
    n_tests++; if (a_sf !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag: got %b expected 0", a_sf); end
    n_tests++; if (a_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_sat_count: got %h expected 0000", a_cnt); end
    rst = 1'b0;
    tick();
    n_tests++; if (a_rr !== 1'b1) begin n_fail++; $display("FAIL reset_raw_ready: got %b expected 1", a_rr); end
    n_tests++; if (c_tv !== 1'b0) begin n_fail++; $display("FAIL reset_tv_c: got %b expected 0", c_tv); end
  endtask

  task automatic test_default();
    a_tr = 1'b1; a_raw = 16'h024E; a_rv = 1'b1;
    tick();
    a_rv = 1'b0; a_raw = 16'h0;
    tick(); tick();
    n_tests++; if (a_tv !== 1'b0) begin n_fail++; $display("FAIL default_early: got tv=%b expected 0", a_tv); end
    tick();
    n_tests++; if (a_tv !== 1'b1) begin n_fail++; $display("FAIL default_latency: got tv=%b expected 1", a_tv); end
    n_tests++; if (a_t !== 32'h0000024E) begin n_fail++; $display("FAIL default_value: got %h expected 0000024e", a_t); end
    n_tests++; if (a_sf !== 1'b0) begin n_fail++; $display("FAIL default_sat_flag: got %b expected 0", a_sf); end
    tick();
    n_tests++; if (a_tv !== 1'b0) begin n_fail++; $display("FAIL default_drain: got tv=%b expected 0", a_tv); end
  endtask

  task automatic test_scaling();
    int vin  [3] = '{200, -32768, 101};
    int vexp [3] = '{150, -49302, 2};
    b_tr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic got;
      int   k;
      b_raw = 16'(vin[i]); b_rv = 1'b1;
      tick();
      b_rv = 1'b0;
      got = 1'b0; k = 0;
      while (!got && k < 10) begin
        if (b_tv === 1'b1) got = 1'b1;
        else begin tick(); k++; end
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL scale_timeout[%0d]: got no output expected %0d", i, vexp[i]); end
      else if (b_t !== 32'(vexp[i])) begin n_fail++; $display("FAIL scale_value[%0d]: got %0d expected %0d", i, b_t, vexp[i]); end
      n_tests++; if (b_sf !== 1'b0) begin n_fail++; $display("FAIL scale_sat_flag[%0d]: got %b expected 0", i, b_sf); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int nin = 1;
    int nexp = 1;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic signed [31:0] prev_t = '0;
    while (nexp <= 8 && cyc < 60) begin
      a_tr  = !(cyc >= 4 && cyc <= 6);
      a_rv  = (nin <= 8);
      a_raw = 16'(nin);
      #1;
      n_tests++;
      if (a_rr !== !(a_tv && !a_tr)) begin n_fail++; $display("FAIL b2b_raw_ready cyc %0d: got %b expected %b", cyc, a_rr, !(a_tv && !a_tr)); end
      if (prev_stall) begin
        n_tests++;
        if (a_tv !== 1'b1 || a_t !== prev_t) begin n_fail++; $display("FAIL b2b_stall_hold cyc %0d: got tv=%b %0d expected tv=1 %0d", cyc, a_tv, a_t, prev_t); end
      end
      if (a_tv && a_tr) begin
        n_tests++;
        if (a_t !== 32'(nexp)) begin n_fail++; $display("FAIL b2b_order: got %0d expected %0d", a_t, nexp); end
        nexp++;
      end
      if (a_rv && a_rr) nin++;
      prev_stall = a_tv && !a_tr;
      prev_t     = a_t;
      cyc++;
      tick();
    end
    a_rv = 1'b0; a_tr = 1'b1;
    n_tests++; if (nexp !== 9) begin n_fail++; $display("FAIL b2b_count: got %0d outputs expected 8", nexp - 1); end
    n_tests++; if (a_tv !== 1'b0) begin n_fail++; $display("FAIL b2b_duplicate: got tv=%b expected 0", a_tv); end
  endtask

  task automatic test_saturation();
    int vin [2] = '{-32768, 32767};
    logic signed [31:0] vexp [2] = '{32'h0000_0000, 32'h8000_0000};
    logic vsat [2] = '{1'b0, 1'b1};
    d_tr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      logic got;
      int   k;
      d_raw = 16'(vin[i]); d_rv = 1'b1;
      tick();
      d_rv = 1'b0;
      got = 1'b0; k = 0;
      while (!got && k < 10) begin
        if (d_tv === 1'b1) got = 1'b1;
        else begin tick(); k++; end
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL sat_neg_timeout[%0d]: got no output expected %h", i, vexp[i]); end
      else if (d_t !== vexp[i]) begin n_fail++; $display("FAIL sat_neg_value[%0d]: got %h expected %h", i, d_t, vexp[i]); end
      n_tests++; if (d_sf !== vsat[i]) begin n_fail++; $display("FAIL sat_neg_flag[%0d]: got %b expected %b", i, d_sf, vsat[i]); end
      tick();
    end
  endtask

  task automatic test_sat_counter();
    c_tr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic got;
      int   k;
      logic [1:0] exp_cnt;
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      c_raw = 16'sh7FFF; c_rv = 1'b1;
      tick();
      c_rv = 1'b0;
      got = 1'b0; k = 0;
      while (!got && k < 10) begin
        if (c_tv === 1'b1) got = 1'b1;
        else begin tick(); k++; end
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL satcnt_timeout[%0d]: got no output expected 7fffffff", i); end
      else if (c_t !== FEAT_MAX) begin n_fail++; $display("FAIL satcnt_value[%0d]: got %h expected 7fffffff", i, c_t); end
      n_tests++; if (c_sf !== 1'b1) begin n_fail++; $display("FAIL satcnt_flag[%0d]: got %b expected 1", i, c_sf); end
      tick();
      n_tests++; if (c_cnt !== exp_cnt) begin n_fail++; $display("FAIL satcnt_count[%0d]: got %0d expected %0d", i, c_cnt, exp_cnt); end
    end
  endtask

  task automatic test_midstream_reset();
    logic seen;
    a_tr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_raw = 16'(100 + i); a_rv = 1'b1;
      tick();
    end
    a_rv = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (a_tv !== 1'b0) begin n_fail++; $display("FAIL mrst_tv: got %b expected 0", a_tv); end
    n_tests++; if (c_cnt !== 2'd0) begin n_fail++; $display("FAIL mrst_sat_count: got %0d expected 0", c_cnt); end
    n_tests++; if (a_t !== 32'h0) begin n_fail++; $display("FAIL mrst_test: got %h expected 00000000", a_t); end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_tv === 1'b1) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mrst_flushed: got stale output %h expected none", a_t); end
    a_raw = 16'h0055; a_rv = 1'b1;
    tick();
    a_rv = 1'b0;
    tick(); tick();
    n_tests++; if (a_tv !== 1'b0) begin n_fail++; $display("FAIL mrst_early: got tv=%b expected 0", a_tv); end
    tick();
    n_tests++;
    if (a_tv !== 1'b1 || a_t !== 32'h0000_0055) begin n_fail++; $display("FAIL mrst_latency: got tv=%b %h expected tv=1 00000055", a_tv, a_t); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_raw = '0; a_rv = 1'b0; a_tr = 1'b1;
    b_raw = '0; b_rv = 1'b0; b_tr = 1'b1;
    c_raw = '0; c_rv = 1'b0; c_tr = 1'b1;
    d_raw = '0; d_rv = 1'b0; d_tr = 1'b1;
    test_reset();
    test_default();
    test_scaling();
    test_back_to_back();
    test_saturation();
    test_sat_counter();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
